bram_stream_reader: RTL

Read-side sequencer for the dual-port BRAM with read enable. It accepts a (base address, length) command, drives the BRAM read port with one-cycle read latency, and emits the words in address order as an AXI-Stream master with full backpressure support. A 2-entry output buffer gives 1 word/cycle throughput and never drops or duplicates a word. It sits directly downstream of the BRAM's port B (or A) and upstream of the KAN compute datapath.

---
 rtl/kan_bram_pkg.sv | 19 +
 rtl/stream_fifo2.sv | 60 ++++++
 rtl/bram_stream_reader.sv | 133 +++++++++++++
 3 files changed

// File: rtl/kan_bram_pkg.sv
// Shared types and constants for the KAN BRAM access blocks.
// Holds the stream-reader FSM encoding, the output buffer depth and the length-width helper.
package kan_bram_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } bsr_state_e;

   localparam int BSR_FIFO_DEPTH = 2;
   localparam int BSR_CNT_W      = 2;

   // One extra bit so a command can cover every address of the BRAM.
   function automatic int bsr_len_width(input int addr_width);
      return addr_width + 1;
   endfunction

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry register FIFO holding {last, data} words between the BRAM read port and the stream.
// The head is always slot 0, so the stream sees a stable register while a beat waits for ready.
module stream_fifo2
   import kan_bram_pkg::*;
#(
   parameter int WIDTH = 33
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 push,
   input  logic [WIDTH-1:0]     push_data,
   input  logic                 pop,
   output logic [BSR_CNT_W-1:0] count,
   output logic [WIDTH-1:0]     head
);

   logic [WIDTH-1:0]     slot_q [BSR_FIFO_DEPTH];
   logic [WIDTH-1:0]     slot_d [BSR_FIFO_DEPTH];
   logic [BSR_CNT_W-1:0] count_q, count_d;

   always_comb begin
      slot_d  = slot_q;
      count_d = count_q;
      case ({push, pop})
         2'b10: begin
            if (count_q == '0) slot_d[0] = push_data;
            else               slot_d[1] = push_data;
            count_d = count_q + BSR_CNT_W'(1);
         end
         2'b01: begin
            slot_d[0] = slot_q[1];
            count_d   = count_q - BSR_CNT_W'(1);
         end
         2'b11: begin
            // Full-buffer push+pop is excluded upstream; handled as a shift so it stays ordered.
            if (count_q == BSR_CNT_W'(1)) begin
               slot_d[0] = push_data;
            end else begin
               slot_d[0] = slot_q[1];
               slot_d[1] = push_data;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count_q <= '0;
         for (int i = 0; i < BSR_FIFO_DEPTH; i++) slot_q[i] <= '0;
      end else begin
         count_q <= count_d;
         for (int i = 0; i < BSR_FIFO_DEPTH; i++) slot_q[i] <= slot_d[i];
      end
   end

   assign count = count_q;
   assign head  = slot_q[0];

endmodule

// File: rtl/bram_stream_reader.sv
// Reads a (base, length) block from a one-cycle-latency BRAM port and replays it as an
// AXI-Stream with full backpressure; read issue is gated so the 2-entry buffer can never overflow.
module bram_stream_reader
   import kan_bram_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int LEN_WIDTH  = bsr_len_width(ADDR_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [LEN_WIDTH-1:0]  length,
   output logic                  busy,
   output logic                  done,
   output logic                  bram_rden,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   input  logic [DATA_WIDTH-1:0] bram_dout,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast
);

   localparam logic [BSR_CNT_W:0] DEPTH_L = (BSR_CNT_W + 1)'(BSR_FIFO_DEPTH);

   bsr_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
   logic                  inflight_q;
   logic                  inflight_last_q;
   logic                  issue_last;
   logic                  accept;

   logic [BSR_CNT_W-1:0]  fifo_count;
   logic [DATA_WIDTH:0]   fifo_head;
   logic                  pop;
   logic                  settled;
   logic [BSR_CNT_W:0]    occupancy;
   logic [BSR_CNT_W:0]    limit;
   logic                  credit_ok;

   assign m_axis_tvalid = (fifo_count != '0);
   assign pop           = m_axis_tvalid & m_axis_tready;
   assign settled       = (fifo_count == '0) && !inflight_q;

   // Words already owned (buffered or in flight) must leave room for the one being issued.
   assign occupancy = {1'b0, fifo_count} + {{BSR_CNT_W{1'b0}}, inflight_q};
   assign limit     = DEPTH_L + {{BSR_CNT_W{1'b0}}, pop};
   assign credit_ok = occupancy < limit;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      bram_rden   = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      accept      = 1'b0;
      issue_last  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            accept = start;
         end
         ST_READ: begin
            busy = 1'b1;
            if (credit_ok) begin
               bram_rden   = 1'b1;
               addr_d      = addr_q + ADDR_WIDTH'(1);
               remaining_d = remaining_q - LEN_WIDTH'(1);
               if (remaining_q == LEN_WIDTH'(1)) begin
                  issue_last = 1'b1;
                  state_d    = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            // The done cycle already counts as idle, so a follow-on command is taken here.
            if (settled) begin
               done    = 1'b1;
               state_d = ST_IDLE;
               accept  = start;
            end else begin
               busy = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (accept) begin
         addr_d      = base_addr;
         remaining_d = length;
         state_d     = (length == '0) ? ST_DRAIN : ST_READ;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q         <= ST_IDLE;
         addr_q          <= '0;
         remaining_q     <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         remaining_q     <= remaining_d;
         inflight_q      <= bram_rden;
         inflight_last_q <= issue_last;
      end
   end

   stream_fifo2 #(
      .WIDTH(DATA_WIDTH + 1)
   ) u_fifo (
      .clk      (clk),
      .rstn     (rstn),
      .push     (inflight_q),
      .push_data({inflight_last_q, bram_dout}),
      .pop      (pop),
      .count    (fifo_count),
      .head     (fifo_head)
   );

   assign bram_addr    = addr_q;
   assign m_axis_tdata = fifo_head[DATA_WIDTH-1:0];
   assign m_axis_tlast = fifo_head[DATA_WIDTH] & m_axis_tvalid;

endmodule
